// File: rtl/core_pkg.sv
// core_pkg: shared state encoding and instruction field positions for core_sequencer
package core_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_XW, S_WW, S_WL0, S_WLOAD, S_GAP, S_AL0, S_EXEC, S_DRAIN, S_ACC, S_DONE
  } state_t;
  localparam int I_ACC      = 33;
  localparam int I_CEN_P    = 32;
  localparam int I_WEN_P    = 31;
  localparam int I_AP_LO    = 20;
  localparam int I_CEN_X    = 19;
  localparam int I_WEN_X    = 18;
  localparam int I_AX_LO    = 7;
  localparam int I_OFIFO_RD = 6;
  localparam int I_IFIFO_WR = 5;
  localparam int I_IFIFO_RD = 4;
  localparam int I_L0_RD    = 3;
  localparam int I_L0_WR    = 2;
  localparam int I_EXEC     = 1;
  localparam int I_LOAD     = 0;
  localparam logic [33:0] INST_IDLE = 34'h1800C0000;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: 11-bit clearable up-counter flagging the final count of a phase
module seq_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [10:0] limit,
  output logic [10:0] count,
  output logic        last
);
  assign last = count == limit - 11'd1;
  // clear wins over increment so every phase starts from zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 11'd1;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: drives the core instruction word through one tile of load/execute/accumulate
module core_sequencer
  import core_pkg::*;
#(
  parameter int          bw     = 4,
  parameter int          row    = 8,
  parameter int          col    = 8,
  parameter int          DRAIN  = 16,
  parameter logic [10:0] W_BASE = 11'd1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       len,
  input  logic              acc,
  input  logic [10:0]       pmem_base,
  input  logic [bw*row-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [33:0]       inst,
  output logic [bw*row-1:0] D_xmem,
  output logic              busy,
  output logic              done
);
  state_t              state, nxt;
  logic [10:0]         tile_len, tile_base, count, limit;
  logic                tile_acc, xfer, en, last, adv, clr;
  logic [33:0]         inst_d;
  logic [bw*row-1:0]   data_d;
  assign in_ready = state == S_XW || state == S_WW;
  assign busy     = state != S_IDLE;
  assign done     = state == S_DONE;
  assign xfer     = in_valid && in_ready;
  assign en       = in_ready ? xfer : 1'b1;
  assign adv      = busy && en && last;
  assign clr      = adv || state == S_IDLE;
  // phase length of the current state
  always_comb begin
    limit = 11'd1;
    unique case (state)
      S_XW, S_AL0, S_EXEC, S_ACC: limit = tile_len;
      S_WW, S_WL0, S_WLOAD:       limit = 11'(col);
      S_GAP:                      limit = 11'(row);
      S_DRAIN:                    limit = 11'(DRAIN);
      default:                    limit = 11'd1;
    endcase
  end
  seq_counter u_cnt (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .limit(limit), .count(count), .last(last)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= nxt;
  // next state: enum order is the phase order, DONE wraps to IDLE
  always_comb begin
    nxt = state;
    if (state == S_IDLE) nxt = (start && len != 11'd0) ? S_XW : S_IDLE;
    else if (adv) nxt = (state == S_DONE) ? S_IDLE : state_t'(state + 4'd1);
  end
  // tile parameters are latched on the accepted start only
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tile_len  <= '0;
      tile_base <= '0;
      tile_acc  <= 1'b0;
    end else if (state == S_IDLE && start && len != 11'd0) begin
      tile_len  <= len;
      tile_base <= pmem_base;
      tile_acc  <= acc;
    end
  // instruction for the current cycle, registered below
  always_comb begin
    inst_d = INST_IDLE;
    data_d = D_xmem;
    unique case (state)
      S_XW, S_WW: if (xfer) begin
        inst_d[I_CEN_X]          = 1'b0;
        inst_d[I_WEN_X]          = 1'b0;
        inst_d[I_AX_LO +: 11]    = state == S_WW ? W_BASE + count : count;
        data_d                   = in_data;
      end
      S_WL0, S_AL0: begin
        inst_d[I_CEN_X]          = 1'b0;
        inst_d[I_AX_LO +: 11]    = state == S_WL0 ? W_BASE + count : count;
        inst_d[I_L0_WR]          = 1'b1;
      end
      S_WLOAD: begin
        inst_d[I_L0_RD]          = 1'b1;
        inst_d[I_LOAD]           = 1'b1;
      end
      S_EXEC: begin
        inst_d[I_L0_RD]          = 1'b1;
        inst_d[I_EXEC]           = 1'b1;
      end
      S_ACC: begin
        inst_d[I_OFIFO_RD]       = 1'b1;
        inst_d[I_CEN_P]          = 1'b0;
        inst_d[I_WEN_P]          = 1'b0;
        inst_d[I_AP_LO +: 11]    = tile_base + count;
        inst_d[I_ACC]            = tile_acc;
      end
      default: ;
    endcase
  end
  // output register for inst and write data
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      inst   <= INST_IDLE;
      D_xmem <= '0;
    end else begin
      inst   <= inst_d;
      D_xmem <= data_d;
    end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed tile runs checking instruction sequences and timing
module tb_core_sequencer;
  import core_pkg::*;
  logic        clk = 1'b0, reset, start, acc, in_valid, in_ready, busy, done;
  logic [10:0] len, pmem_base;
  logic [31:0] in_data, D_xmem;
  logic [33:0] inst;
  int          nvec = 0, nerr = 0;
  logic [10:0] pa [4] = '{11'd2046, 11'd2047, 11'd0, 11'd1};
  always #5 clk = ~clk;
  core_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .acc(acc), .pmem_base(pmem_base),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .D_xmem(D_xmem), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int wr, l0w, ld, ex, ofr, dn, k, nd, nb;
    reset = 1'b0; start = 1'b0; acc = 1'b0; in_valid = 1'b0;
    len = '0; pmem_base = '0; in_data = '0;
    tick; tick;
    chk("rst inst", inst, INST_IDLE);
    chk("rst busy", busy, 0);
    chk("rst ready", in_ready, 0);
    chk("rst done", done, 0);
    chk("rst dx", D_xmem, 0);
    reset = 1'b1;
    tick;
    // basic tile, len=4, valid always high
    len = 11'd4; in_valid = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    wr = 0; l0w = 0; ld = 0; ex = 0; ofr = 0; dn = -1;
    for (int n = 1; n <= 100 && dn < 0; n++) begin
      in_data = 32'hB000_0000 | n;
      tick;
      if (!inst[I_CEN_X] && !inst[I_WEN_X]) begin
        chk("t1 xaddr", inst[17:7], wr < 4 ? wr : 1024 + wr - 4);
        chk("t1 xdata", D_xmem, 32'hB000_0000 | n);
        wr++;
      end
      l0w += inst[I_L0_WR]; ld += inst[I_LOAD]; ex += inst[I_EXEC]; ofr += inst[I_OFIFO_RD];
      if (done) dn = n;
    end
    chk("t1 writes", wr, 12);
    chk("t1 l0_wr", l0w, 12);
    chk("t1 load", ld, 8);
    chk("t1 exec", ex, 4);
    chk("t1 ofifo", ofr, 4);
    chk("t1 done cyc", dn, 64);
    tick;
    chk("t1 idle busy", busy, 0);
    chk("t1 idle inst", inst, INST_IDLE);
    // in_valid toggling: transfers only on odd cycles
    len = 11'd4; start = 1'b1;
    tick;
    start = 1'b0;
    wr = 0; dn = -1;
    for (int n = 1; n <= 120 && dn < 0; n++) begin
      in_valid = n[0];
      in_data = 32'hA000_0000 | n;
      tick;
      if (!inst[I_CEN_X] && !inst[I_WEN_X]) begin
        chk("t2 wcyc", n, 2 * wr + 1);
        chk("t2 xaddr", inst[17:7], wr < 4 ? wr : 1024 + wr - 4);
        chk("t2 xdata", D_xmem, 32'hA000_0000 | n);
        wr++;
      end
      if (done) dn = n;
    end
    chk("t2 writes", wr, 12);
    chk("t2 done cyc", dn, 75);
    in_valid = 1'b1;
    tick;
    // psum address wrap with acc, inputs changed after start
    len = 11'd4; acc = 1'b1; pmem_base = 11'd2046; start = 1'b1;
    tick;
    start = 1'b0; acc = 1'b0; pmem_base = 11'd5; len = 11'd9;
    k = 0; dn = -1;
    for (int n = 1; n <= 100 && dn < 0; n++) begin
      tick;
      if (!inst[I_CEN_P]) begin
        chk("t3 paddr", inst[30:20], k < 4 ? pa[k] : 11'h7FF);
        chk("t3 acc", inst[I_ACC], 1);
        chk("t3 pwen", inst[I_WEN_P], 0);
        k++;
      end
      if (done) dn = n;
    end
    chk("t3 pwrites", k, 4);
    chk("t3 done cyc", dn, 64);
    tick;
    // reset during EXEC, then a fresh tile
    len = 11'd4; start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 1; n <= 41; n++) tick;
    chk("t4 exec", inst[I_EXEC], 1);
    #2 reset = 1'b0;
    #1;
    chk("t4 rst inst", inst, INST_IDLE);
    chk("t4 rst busy", busy, 0);
    chk("t4 rst ready", in_ready, 0);
    chk("t4 rst dx", D_xmem, 0);
    tick;
    reset = 1'b1;
    tick;
    chk("t4 no resume", busy, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t4 restart ready", in_ready, 1);
    in_data = 32'h1234_5678;
    tick;
    chk("t4 first wen", inst[I_WEN_X], 0);
    chk("t4 first addr", inst[17:7], 0);
    chk("t4 first data", D_xmem, 32'h1234_5678);
    reset = 1'b0;
    #1 reset = 1'b1;
    tick;
    // len=0 start ignored
    len = 11'd0; start = 1'b1;
    tick;
    start = 1'b0;
    nd = 0; nb = 0;
    for (int n = 0; n < 5; n++) begin
      tick;
      nd += done; nb += busy;
    end
    chk("t5 len0 busy", nb, 0);
    chk("t5 len0 done", nd, 0);
    // start during ACC ignored
    len = 11'd2; start = 1'b1;
    tick;
    start = 1'b0;
    nd = 0; dn = -1;
    for (int n = 1; n <= 80; n++) begin
      start = n == 55;
      len = 11'd3;
      tick;
      if (done) begin
        nd++;
        if (dn < 0) dn = n;
      end
    end
    start = 1'b0;
    chk("t5 one done", nd, 1);
    chk("t5 done cyc", dn, 56);
    chk("t5 end busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
